// File: rtl/prefetch_queue_pkg.sv
// Shared types and width helpers for the instruction prefetch queue.
package prefetch_queue_pkg;

   typedef enum logic [1:0] {
      PF_IDLE,
      PF_WAIT,
      PF_STALE
   } pf_state_e;

   localparam int DEF_DEPTH     = 8;
   localparam int DEF_BUS_BYTES = 2;
   localparam int DEF_PEEK      = 6;
   localparam int DEF_PC_W      = 16;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/prefetch_queue_ring_buffer.sv
// Byte ring storage: masked multi-byte write at wr_ptr, PEEK-byte window at rd_ptr.
module pf_ring_buffer
   import prefetch_queue_pkg::*;
#(
   parameter int DEPTH     = DEF_DEPTH,
   parameter int BUS_BYTES = DEF_BUS_BYTES,
   parameter int PEEK      = DEF_PEEK
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [ptr_w(DEPTH)-1:0] wr_ptr,
   input  logic [BUS_BYTES*8-1:0] wr_data,
   input  logic [BUS_BYTES-1:0]   wr_mask,
   input  logic [ptr_w(DEPTH)-1:0] rd_ptr,
   output logic [PEEK*8-1:0]      window
);

   localparam int PW = ptr_w(DEPTH);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int j = 0; j < BUS_BYTES; j++) begin
         if (we && wr_mask[j]) begin
            mem[PW'(wr_ptr + PW'(j))] <= wr_data[j*8 +: 8];
         end
      end
   end

   always_comb begin
      window = '0;
      for (int i = 0; i < PEEK; i++) begin
         window[i*8 +: 8] = mem[PW'(rd_ptr + PW'(i))];
      end
   end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: PFP/pointer/count registers and single-outstanding
// fill FSM feeding a byte ring buffer.
module prefetch_queue
   import prefetch_queue_pkg::*;
#(
   parameter int DEPTH     = DEF_DEPTH,
   parameter int BUS_BYTES = DEF_BUS_BYTES,
   parameter int PEEK      = DEF_PEEK,
   parameter int PC_W      = DEF_PC_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ce,
   input  logic                      flush,
   input  logic [PC_W-1:0]           flush_pc,
   output logic                      fill_req,
   output logic [PC_W-1:0]           fill_addr,
   input  logic                      fill_ack,
   input  logic [BUS_BYTES*8-1:0]    fill_data,
   output logic [PEEK*8-1:0]         q_window,
   output logic [cnt_w(DEPTH)-1:0]   q_len,
   input  logic [cnt_w(PEEK)-1:0]    consume
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam int BW = BUS_BYTES * 8;

   pf_state_e state, state_nx;

   logic [PW-1:0]        rd_ptr, wr_ptr;
   logic [CW-1:0]        count;
   logic [PC_W-1:0]      pfp;
   logic [PC_W-1:0]      skip, fill_bytes;
   logic                 room, take;
   logic [BW-1:0]        wr_data;
   logic [BUS_BYTES-1:0] wr_mask;

   assign skip       = pfp & PC_W'(BUS_BYTES - 1);
   assign fill_bytes = PC_W'(BUS_BYTES) - skip;
   assign room       = (CW'(DEPTH) - count) >= CW'(BUS_BYTES);
   // A flush in the ack cycle drops the data but still retires the request.
   assign take       = ce && !flush && fill_ack && (state == PF_WAIT);

   assign wr_data = fill_data >> {skip, 3'b000};

   always_comb begin
      wr_mask = '0;
      for (int j = 0; j < BUS_BYTES; j++) begin
         wr_mask[j] = PC_W'(j) < fill_bytes;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         PF_IDLE:  if (!flush && room) state_nx = PF_WAIT;
         PF_WAIT: begin
            if (fill_ack)   state_nx = PF_IDLE;
            else if (flush) state_nx = PF_STALE;
         end
         PF_STALE: if (fill_ack) state_nx = PF_IDLE;
         default:  state_nx = PF_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= PF_IDLE;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         pfp    <= '0;
      end else if (ce) begin
         state <= state_nx;
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pfp    <= flush_pc;
         end else begin
            rd_ptr <= rd_ptr + PW'(consume);
            count  <= count + (take ? CW'(fill_bytes) : '0) - CW'(consume);
            if (take) begin
               wr_ptr <= wr_ptr + PW'(fill_bytes);
               pfp    <= pfp + fill_bytes;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && ce && !flush) begin
         assert (CW'(consume) <= count);
      end
   end

   assign fill_req  = (state == PF_WAIT);
   assign fill_addr = pfp & ~PC_W'(BUS_BYTES - 1);
   assign q_len     = count;

   pf_ring_buffer #(
      .DEPTH     (DEPTH),
      .BUS_BYTES (BUS_BYTES),
      .PEEK      (PEEK)
   ) u_ring (
      .clk     (clk),
      .we      (take),
      .wr_ptr  (wr_ptr),
      .wr_data (wr_data),
      .wr_mask (wr_mask),
      .rd_ptr  (rd_ptr),
      .window  (q_window)
   );

endmodule

// File: tb/tb_prefetch_queue.sv
// Scoreboard bench for prefetch_queue: expected queue bytes pushed on fill, popped on consume.
module tb_prefetch_queue;

   localparam int PEEK = 6;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ce = 1'b1;
   logic        flush = 1'b0;
   logic [15:0] flush_pc = '0;
   logic        fill_req;
   logic [15:0] fill_addr;
   logic        fill_ack = 1'b0;
   logic [15:0] fill_data = '0;
   logic [47:0] q_window;
   logic [3:0]  q_len;
   logic [2:0]  consume = '0;

   int checks = 0;
   int failures = 0;

   byte unsigned sb[$];
   logic [15:0]  m_pfp = '0;
   logic         m_stale = 1'b0;

   always #5 clk = ~clk;

   prefetch_queue dut (
      .clk       (clk),
      .reset     (reset),
      .ce        (ce),
      .flush     (flush),
      .flush_pc  (flush_pc),
      .fill_req  (fill_req),
      .fill_addr (fill_addr),
      .fill_ack  (fill_ack),
      .fill_data (fill_data),
      .q_window  (q_window),
      .q_len     (q_len),
      .consume   (consume)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] mbyte(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic logic [15:0] data_at(input logic [15:0] a);
      return {mbyte(a + 16'd1), mbyte(a)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_window(input string tag);
      logic [47:0] exp, mask;
      exp = '0;
      mask = '0;
      for (int i = 0; i < PEEK && i < sb.size(); i++) begin
         exp[i*8 +: 8] = sb[i];
         mask[i*8 +: 8] = 8'hFF;
      end
      check({tag, "_len"}, q_len, sb.size());
      check({tag, "_win"}, q_window & mask, exp);
   endtask

   task automatic drive(input int n, input logic ack, input logic [15:0] data);
      int skip;
      consume = 3'(n);
      fill_ack = ack;
      fill_data = data;
      for (int i = 0; i < n; i++) void'(sb.pop_front());
      if (ack) begin
         if (m_stale) m_stale = 1'b0;
         else begin
            skip = int'(m_pfp[0]);
            for (int i = skip; i < 2; i++) sb.push_back(data[i*8 +: 8]);
            m_pfp = m_pfp + 16'(2 - skip);
         end
      end
      tick();
      consume = '0;
      fill_ack = 1'b0;
   endtask

   task automatic do_flush(input logic [15:0] pc);
      flush = 1'b1;
      flush_pc = pc;
      if (fill_req) m_stale = 1'b1;
      sb.delete();
      m_pfp = pc;
      tick();
      flush = 1'b0;
   endtask

   task automatic clean_flush(input logic [15:0] pc);
      do_flush(pc);
      if (m_stale) drive(0, 1'b1, 16'hDEAD);
   endtask

   task automatic wait_req();
      for (int i = 0; i < 20 && !fill_req; i++) tick();
      check("req_seen", fill_req, 1'b1);
   endtask

   task automatic fill(input logic [15:0] data, input int n);
      wait_req();
      check("fill_addr", fill_addr, m_pfp & 16'hFFFE);
      drive(n, 1'b1, data);
      check_window("fill");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int fills;
      int n;
      logic saw_fffe, saw_zero;

      // reset state
      reset = 1'b1;
      tick();
      tick();
      check("rst_len", q_len, 0);
      check("rst_req", fill_req, 0);
      check("rst_addr", fill_addr, 0);
      reset = 1'b0;

      // 1: aligned fills to full, then stall
      do_flush(16'h0000);
      for (int k = 0; k < 4; k++) begin
         fill(16'h3412, 0);
         check("t1_len", q_len, 2 * (k + 1));
      end
      for (int k = 0; k < 4; k++) tick();
      check("t1_stall_req", fill_req, 0);
      check("t1_head", q_window[15:0], 16'h3412);

      // ce=0 ignores every input
      ce = 1'b0;
      consume = 3'd2;
      flush = 1'b1;
      flush_pc = 16'h1234;
      fill_ack = 1'b1;
      tick();
      ce = 1'b1;
      consume = '0;
      flush = 1'b0;
      fill_ack = 1'b0;
      check("ce_len", q_len, 8);
      check("ce_addr", fill_addr, m_pfp & 16'hFFFE);
      check_window("ce");

      // 2: misaligned first fetch
      clean_flush(16'h0101);
      wait_req();
      check("t2_addr0", fill_addr, 16'h0100);
      drive(0, 1'b1, 16'hAA55);
      check("t2_len", q_len, 1);
      check("t2_byte", q_window[7:0], 8'hAA);
      wait_req();
      check("t2_addr1", fill_addr, 16'h0102);

      // 3: full, consume, then fill+consume together
      clean_flush(16'h0200);
      for (int k = 0; k < 4; k++) fill(data_at(m_pfp & 16'hFFFE), 0);
      check("t3_full", q_len, 8);
      drive(2, 1'b0, '0);
      check_window("t3_c2");
      drive(0, 1'b0, '0);
      check("t3_req", fill_req, 1);
      check("t3_addr", fill_addr, m_pfp & 16'hFFFE);
      drive(3, 1'b1, data_at(m_pfp & 16'hFFFE));
      check("t3_len5", q_len, 5);
      check_window("t3_mix");

      // 4: flush with a fill outstanding, stale ack dropped
      wait_req();
      do_flush(16'h0300);
      check("t4_req_off", fill_req, 0);
      drive(0, 1'b1, 16'hBEEF);
      check("t4_len", q_len, 0);
      fill(data_at(16'h0300), 0);
      check("t4_pfp", fill_addr, 16'h0302);

      // 5: trickle consume across PFP wrap
      clean_flush(16'hFFE0);
      fills = 0;
      saw_fffe = 1'b0;
      saw_zero = 1'b0;
      for (int c = 0; c < 2000 && fills < 40; c++) begin
         n = (sb.size() > 0) ? 1 : 0;
         if (fill_req) begin
            if (fill_addr == 16'hFFFE) saw_fffe = 1'b1;
            if (saw_fffe && fill_addr == 16'h0000) saw_zero = 1'b1;
            check("t5_addr", fill_addr, m_pfp & 16'hFFFE);
            drive(n, 1'b1, data_at(m_pfp & 16'hFFFE));
            fills++;
         end else begin
            drive(n, 1'b0, '0);
         end
         check_window("t5");
      end
      check("t5_fills", fills, 40);
      check("t5_wrap", {saw_fffe, saw_zero}, 2'b11);

      // 6: reset mid-fill, stray ack ignored
      wait_req();
      reset = 1'b1;
      tick();
      check("t6_req", fill_req, 0);
      check("t6_len0", q_len, 0);
      reset = 1'b0;
      fill_ack = 1'b1;
      fill_data = 16'hCAFE;
      sb.delete();
      m_pfp = '0;
      m_stale = 1'b0;
      tick();
      fill_ack = 1'b0;
      check("t6_len", q_len, 0);
      fill(data_at(16'h0000), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
